// File: rtl/misc_loader.sv
// misc_loader: host word stream -> misc bus write initiator that fills memory before the CPU runs.
// Latency: address + count words, then 2+STROBE cycles per payload word (+1 in WAIT_W); done follows the last HOLD.
// Backpressure: s_ready is high only in IDLE, CNT and WAIT_W; the host holds s_valid/s_data until accepted.
//
// Optional build macro: MISC_LOADER_VERIFY_EN adds a read-back of every written word (VREAD/VCMP) and a
// sticky error flag; without it error is tied low and data_in is ignored.
//
// Ports:
//   clock, reset         single clock, synchronous active-high reset
//   s_valid/s_data/s_ready  host word stream: start address, word count, then payload words
//   bus_req/bus_gnt      ownership handshake with the misc core (gnt only sampled while requesting)
//   addr, data_out, data_oe, csel, rw   misc bus initiator outputs (rw=1 read/idle, 0 write)
//   data_in              read data from the bus (read-back only)
//   busy, done, error    load in progress, one-cycle completion pulse, sticky read-back mismatch

module misc_loader #(
    parameter int l      = 16,
    parameter int STROBE = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         s_valid,
    input  logic [l-1:0] s_data,
    output logic         s_ready,
    output logic         bus_req,
    input  logic         bus_gnt,
    output logic [l-1:0] addr,
    output logic [l-1:0] data_out,
    input  logic [l-1:0] data_in,
    output logic         data_oe,
    output logic         csel,
    output logic         rw,
    output logic         busy,
    output logic         done,
    output logic         error
);

`ifdef MISC_LOADER_VERIFY_EN
    typedef enum logic [3:0] {
        S_IDLE, S_CNT, S_REQ, S_WAIT_W, S_SETUP, S_STROBE, S_HOLD, S_DONE, S_VREAD, S_VCMP
    } state_t;
`else
    typedef enum logic [3:0] {
        S_IDLE, S_CNT, S_REQ, S_WAIT_W, S_SETUP, S_STROBE, S_HOLD, S_DONE
    } state_t;
`endif

    state_t         state_q;
    state_t         state_d;

    logic [l-1:0]   addr_q;
    logic [l-1:0]   count_q;
    logic [l-1:0]   data_q;
    logic [3:0]     scnt_q;

    logic           rdy_state;
    logic           accept;
    logic           ld_addr;
    logic           ld_cnt;
    logic           ld_data;
    logic           advance;
    logic           scnt_inc;
    logic           last_word;
    logic           last_strobe;

`ifdef MISC_LOADER_VERIFY_EN
    logic [l-1:0]   rdata_q;
    logic           error_q;
    logic           rd_cap;
    logic           set_err;
`endif

    // s_ready is masked by reset so every output reads as idle while reset is held,
    // even though the state register already sits in IDLE.
    assign s_ready     = rdy_state & ~reset;
    assign accept      = s_valid & s_ready;
    assign last_word   = (count_q == l'(1));
    assign last_strobe = (scnt_q == 4'(STROBE - 1));

    assign addr     = addr_q;
    assign data_out = data_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus outputs, decoded from the registered state so the
    // bus pins only move right after a clock edge.
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        rdy_state = 1'b0;
        bus_req   = 1'b0;
        data_oe   = 1'b0;
        csel      = 1'b0;
        rw        = 1'b1;
        busy      = 1'b1;
        done      = 1'b0;
        ld_addr   = 1'b0;
        ld_cnt    = 1'b0;
        ld_data   = 1'b0;
        advance   = 1'b0;
        scnt_inc  = 1'b0;
`ifdef MISC_LOADER_VERIFY_EN
        rd_cap    = 1'b0;
        set_err   = 1'b0;
`endif

        unique case (state_q)
            S_IDLE: begin
                busy      = 1'b0;
                rdy_state = 1'b1;
                if (accept) begin
                    ld_addr = 1'b1;
                    state_d = S_CNT;
                end
            end

            S_CNT: begin
                rdy_state = 1'b1;
                if (accept) begin
                    ld_cnt  = 1'b1;
                    // An empty load never touches the bus.
                    state_d = (s_data == '0) ? S_DONE : S_REQ;
                end
            end

            S_REQ: begin
                bus_req = 1'b1;
                if (bus_gnt) begin
                    state_d = S_WAIT_W;
                end
            end

            S_WAIT_W: begin
                bus_req   = 1'b1;
                rdy_state = 1'b1;
                if (accept) begin
                    ld_data = 1'b1;
                    state_d = S_SETUP;
                end
            end

            S_SETUP: begin
                // addr/data/rw settle a full cycle before csel rises.
                bus_req = 1'b1;
                data_oe = 1'b1;
                rw      = 1'b0;
                state_d = S_STROBE;
            end

            S_STROBE: begin
                bus_req = 1'b1;
                data_oe = 1'b1;
                rw      = 1'b0;
                csel    = 1'b1;
                if (last_strobe) begin
                    state_d = S_HOLD;
                end else begin
                    scnt_inc = 1'b1;
                end
            end

            S_HOLD: begin
                // csel drops while addr/data stay driven for one more cycle.
                bus_req = 1'b1;
                data_oe = 1'b1;
                rw      = 1'b0;
`ifdef MISC_LOADER_VERIFY_EN
                state_d = S_VREAD;
`else
                advance = 1'b1;
                state_d = last_word ? S_DONE : S_WAIT_W;
`endif
            end

`ifdef MISC_LOADER_VERIFY_EN
            S_VREAD: begin
                // scnt 0 is a turnaround cycle: rw has just gone high and data_oe
                // low, so csel waits one cycle before rising. csel is then high for
                // scnt 1..STROBE and data_in is captured on the last of them.
                bus_req = 1'b1;
                csel    = (scnt_q != 4'd0);
                if (scnt_q == 4'(STROBE)) begin
                    rd_cap  = 1'b1;
                    state_d = S_VCMP;
                end else begin
                    scnt_inc = 1'b1;
                end
            end

            S_VCMP: begin
                bus_req = 1'b1;
                if (rdata_q != data_q) begin
                    // Abandon the remaining words: the memory cannot be trusted.
                    set_err = 1'b1;
                    state_d = S_DONE;
                end else begin
                    advance = 1'b1;
                    state_d = last_word ? S_DONE : S_WAIT_W;
                end
            end
`endif

            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Address / count / data / strobe counter
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            scnt_q  <= '0;
        end else begin
            if (ld_addr) begin
                addr_q <= s_data;
            end else if (advance) begin
                // Wraps naturally at 2^l.
                addr_q <= addr_q + l'(1);
            end

            if (ld_cnt) begin
                count_q <= s_data;
            end else if (advance) begin
                count_q <= count_q - l'(1);
            end

            if (ld_data) begin
                data_q <= s_data;
            end

            // Counter is only live inside a strobe window; any other state clears it.
            scnt_q <= scnt_inc ? (scnt_q + 4'd1) : 4'd0;
        end
    end

`ifdef MISC_LOADER_VERIFY_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            if (rd_cap) begin
                rdata_q <= data_in;
            end
            if (set_err) begin
                error_q <= 1'b1;
            end
        end
    end

    assign error = error_q;
`else
    logic unused_data_in;
    assign unused_data_in = ^data_in;
    assign error          = 1'b0;
`endif

endmodule
